traffic_sensor_interface: RTL and testbench
===========================================

Name: traffic_sensor_interface

Overview:
- Produces the controller's request inputs Sa/Sb from raw street vehicle-loop detectors.
- Closes the loop by consuming the controller's six lamp outputs, so it is the sensor-side (opposite) end of the lamp/sensor interface.
- Per street: synchronises and debounces the detector, latches a service request until that street has been served green, and counts arrivals.
- Also monitors the lamp outputs for illegal combinations and raises a sticky fault.

Parameters:
- DEBOUNCE, 4, consecutive cycles a synchronised detector level must differ from the current stable level before the stable level changes (must be ≥1).
- CNT_W, 8, width of each saturating per-street arrival counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- det_a  in  1  raw loop detector, street A; asynchronous to clk.
- det_b  in  1  raw loop detector, street B; asynchronous to clk.
- Ra, Ya, Ga  in  1 each  street A lamp outputs from the controller.
- Rb, Yb, Gb  in  1 each  street B lamp outputs from the controller.
- cnt_clr  in  1  synchronous clear of both arrival counters.
- fault_clr  in  1  synchronous clear of fault and fault_code.
- Sa  out  1  street A service request to the controller.
- Sb  out  1  street B service request to the controller.
- cnt_a  out  CNT_W  street A arrivals, saturating.
- cnt_b  out  CNT_W  street B arrivals, saturating.
- fault  out  1  sticky lamp-fault flag.
- fault_code  out  2  cause of the first fault: 1 = A not one-hot, 2 = B not one-hot, 3 = both streets non-red.

Behaviour:
- Reset (async assert, sync release): all sync flops, stable levels, debounce counters, Sa, Sb, cnt_a, cnt_b, fault and fault_code are 0.
- Synchroniser: det_x passes through 2 flops to give sync_x.
- Debounce:
  - Counter clears whenever sync_x equals stable_x.
  - Otherwise it increments; on reaching DEBOUNCE, stable_x takes sync_x and the counter clears.
  - Any excursion shorter than DEBOUNCE cycles is ignored.
- Request latch (registered, drives Sx):
  - Set when stable_x = 1.
  - Cleared when own green Gx = 1 and stable_x = 0.
  - Set dominates; a request with no vehicle present and no green holds indefinitely.
- Latency: det_x rising, held stable, reaches Sx = 1 after exactly DEBOUNCE+3 rising edges (2 sync, DEBOUNCE debounce, 1 latch). Release latency is the same.
- Arrival counter:
  - Increments on the stable_x 0→1 transition and saturates at 2^CNT_W−1 (no wrap).
  - cnt_clr takes priority over an increment in the same cycle.
- Lamp monitor: evaluated every cycle from the lamp inputs, combinationally detected and registered.
  - viol_a = {Ra,Ya,Ga} not exactly one-hot; viol_b likewise for B.
  - conflict = !Ra & !Rb.
  - While fault = 0, any violation sets fault = 1 and latches fault_code with priority conflict(3) > viol_a(1) > viol_b(2).
  - While fault = 1, fault_code is frozen and later violations are ignored.
  - fault_clr clears both; if a violation is present in the same cycle, the set wins and the code is re-latched.
- Monitoring starts on the first edge after reset_n deasserts.
- Reset mid-operation immediately zeroes all state, including pending requests and in-progress debounce counts.

Decomposition:
- Shared package: fault_code constants FLT_NONE=0, FLT_A=1, FLT_B=2, FLT_CONFLICT=3.
- Sub-module sensor_channel:
  - Contains sync, debounce, request latch and arrival counter.
  - Ports: clk, reset_n, det, green, cnt_clr, req, cnt; parameters DEBOUNCE and CNT_W.
  - Instantiated twice, once per street.
- Lamp monitor stays in the top level.

Test Plan:
- Reset: reset_n=0 with det_a=det_b=1 and Ga=1 → Sa=Sb=0, cnt_a=cnt_b=0, fault=0 throughout reset.
- Glitch rejection and latency:
  - det_a high for 3 cycles → Sa stays 0 and cnt_a stays 0.
  - det_a held high → Sa=1 exactly on the 7th rising edge; cnt_a=1.
- Service handshake:
  - Sa=1 with lamps Ga=1, Rb=1 and det_a dropped → Sa falls 7 edges after det_a falls.
  - With Ga=0 instead, Sa stays 1 indefinitely.
- Saturation and clear:
  - CNT_W=3, 9 debounced det_b arrivals → cnt_b=7.
  - cnt_clr pulsed together with a stable_b rise → cnt_b=0.
- Fault priority and stickiness:
  - Ga=1, Yb=1, Ra=Rb=0 in one cycle → fault=1, code=3.
  - A following Ra+Ga violation leaves code=3.
  - fault_clr with legal lamps → fault=0, code=0.
- Simultaneous faults:
  - Ra=Ga=1 and Rb=Gb=1 in the same cycle → code=1.
  - fault_clr while Ya=Ga=1 → fault stays 1, code=1.

Source files
------------

// File: rtl/traffic_sensor_interface_pkg.sv
// Shared definitions for the traffic sensor interface: fault cause codes
// and the lamp legality helper.
package traffic_sensor_interface_pkg;

    localparam int unsigned FLT_W = 2;

    localparam logic [FLT_W-1:0] FLT_NONE     = 2'd0;
    localparam logic [FLT_W-1:0] FLT_A        = 2'd1;
    localparam logic [FLT_W-1:0] FLT_B        = 2'd2;
    localparam logic [FLT_W-1:0] FLT_CONFLICT = 2'd3;

    // A street's {R,Y,G} lamps are legal only when exactly one is lit.
    function automatic logic lamp_onehot(input logic [2:0] ryg);
        return (ryg == 3'b001) || (ryg == 3'b010) || (ryg == 3'b100);
    endfunction

endpackage

// File: rtl/sensor_channel.sv
// One street's detector path: 2-flop synchroniser, debouncer, service
// request latch and saturating arrival counter.
module sensor_channel
    import traffic_sensor_interface_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             det,
    input  logic             green,
    input  logic             cnt_clr,
    output logic             req,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned      DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            flip_c;
    logic            rise_c;

    // Stable level flips on the DEBOUNCE-th consecutive differing sample.
    assign flip_c = (sync2 != stable) && (db_cnt == DB_LAST);
    assign rise_c = flip_c && sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= det;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == stable) begin
            db_cnt <= '0;
        end else if (flip_c) begin
            stable <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Vehicle presence dominates; only own green with no vehicle releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req <= 1'b0;
        end else if (stable) begin
            req <= 1'b1;
        end else if (green) begin
            req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (rise_c && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_sensor_interface.sv
// Sensor-side end of the lamp/sensor interface: per-street request
// generation plus a sticky monitor for illegal lamp combinations.
module traffic_sensor_interface
    import traffic_sensor_interface_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             det_a,
    input  logic             det_b,
    input  logic             Ra,
    input  logic             Ya,
    input  logic             Ga,
    input  logic             Rb,
    input  logic             Yb,
    input  logic             Gb,
    input  logic             cnt_clr,
    input  logic             fault_clr,
    output logic             Sa,
    output logic             Sb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             fault,
    output logic [FLT_W-1:0] fault_code
);

    logic             viol_a_c;
    logic             viol_b_c;
    logic             conflict_c;
    logic             any_viol_c;
    logic [FLT_W-1:0] code_c;

    sensor_channel #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_chan_a (
        .clk     (clk),
        .reset_n (reset_n),
        .det     (det_a),
        .green   (Ga),
        .cnt_clr (cnt_clr),
        .req     (Sa),
        .cnt     (cnt_a)
    );

    sensor_channel #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_chan_b (
        .clk     (clk),
        .reset_n (reset_n),
        .det     (det_b),
        .green   (Gb),
        .cnt_clr (cnt_clr),
        .req     (Sb),
        .cnt     (cnt_b)
    );

    // Cause priority: both streets non-red, then A, then B.
    always_comb begin
        viol_a_c   = !lamp_onehot({Ra, Ya, Ga});
        viol_b_c   = !lamp_onehot({Rb, Yb, Gb});
        conflict_c = !Ra && !Rb;
        any_viol_c = viol_a_c || viol_b_c || conflict_c;
        code_c     = FLT_NONE;
        if (conflict_c) begin
            code_c = FLT_CONFLICT;
        end else if (viol_a_c) begin
            code_c = FLT_A;
        end else if (viol_b_c) begin
            code_c = FLT_B;
        end
    end

    // A set in the same cycle as fault_clr wins and re-latches the cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else if (any_viol_c && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            fault_code <= code_c;
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end
    end

endmodule

// File: tb/tb_traffic_sensor_interface.sv
// Scoreboard bench for traffic_sensor_interface: directed scenarios then
// randomized traffic, checked against a history-based reference model.
module tb_traffic_sensor_interface;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    // lamps packed as {Ra,Ya,Ga,Rb,Yb,Gb}
    localparam logic [5:0] L_RR = 6'b100_100;
    localparam logic [5:0] L_AG = 6'b001_100;
    localparam logic [5:0] L_AY = 6'b010_100;
    localparam logic [5:0] L_BG = 6'b100_001;
    localparam logic [5:0] L_BY = 6'b100_010;

    logic             clk;
    logic             reset_n;
    logic             det_a, det_b;
    logic             Ra, Ya, Ga, Rb, Yb, Gb;
    logic             cnt_clr, fault_clr;
    logic             Sa, Sb;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             fault;
    logic [1:0]       fault_code;

    typedef struct packed {
        logic             sa;
        logic             sb;
        logic [CNT_W-1:0] ca;
        logic [CNT_W-1:0] cb;
        logic             flt;
        logic [1:0]       code;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 0;

    // Reference model state: full synchronised-sample history since reset.
    logic [1:0] hist[$];
    int         last_flip[2];
    bit         m_stable[2];
    bit         m_req[2];
    int         m_cnt[2];
    bit         m_fault;
    int         m_code;

    traffic_sensor_interface #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .det_a      (det_a),
        .det_b      (det_b),
        .Ra         (Ra),
        .Ya         (Ya),
        .Ga         (Ga),
        .Rb         (Rb),
        .Yb         (Yb),
        .Gb         (Gb),
        .cnt_clr    (cnt_clr),
        .fault_clr  (fault_clr),
        .Sa         (Sa),
        .Sb         (Sb),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        hist.delete();
        hist.push_back(2'b00);
        hist.push_back(2'b00);
        for (int s = 0; s < 2; s++) begin
            last_flip[s] = -1;
            m_stable[s]  = 0;
            m_req[s]     = 0;
            m_cnt[s]     = 0;
        end
        m_fault = 0;
        m_code  = 0;
    endtask

    // One rising edge: the sample seen now is the detector value from two edges ago.
    task automatic model_edge(input logic [1:0] det, input logic [5:0] lamps,
                              input bit cclr, input bit fclr);
        int  m;
        bit  all_differ;
        bit  old;
        bit  rise;
        bit  green[2];
        bit  va, vb, conf;
        hist.push_back(det);
        m        = hist.size() - 3;
        green[0] = lamps[3];
        green[1] = lamps[0];
        for (int s = 0; s < 2; s++) begin
            old  = m_stable[s];
            rise = 0;
            all_differ = (m - int'(DEBOUNCE) + 1) > last_flip[s];
            if (all_differ) begin
                for (int i = 0; i < int'(DEBOUNCE); i++) begin
                    if (hist[m - i][s] == old) all_differ = 0;
                end
            end
            if (all_differ) begin
                m_stable[s]  = !old;
                last_flip[s] = m;
                rise         = !old;
            end
            if (old)           m_req[s] = 1;
            else if (green[s]) m_req[s] = 0;
            if (cclr)                            m_cnt[s] = 0;
            else if (rise && m_cnt[s] < CNT_MAX) m_cnt[s] = m_cnt[s] + 1;
        end
        va   = $countones(lamps[5:3]) != 1;
        vb   = $countones(lamps[2:0]) != 1;
        conf = !lamps[5] && !lamps[2];
        if ((va || vb || conf) && (!m_fault || fclr)) begin
            m_fault = 1;
            m_code  = conf ? 3 : (va ? 1 : 2);
        end else if (fclr) begin
            m_fault = 0;
            m_code  = 0;
        end
    endtask

    task automatic cyc(input bit rst, input logic [1:0] det, input logic [5:0] lamps,
                       input bit cclr, input bit fclr);
        exp_t e;
        @(negedge clk);
        reset_n   = !rst;
        det_a     = det[0];
        det_b     = det[1];
        {Ra, Ya, Ga, Rb, Yb, Gb} = lamps;
        cnt_clr   = cclr;
        fault_clr = fclr;
        if (rst) model_reset();
        else     model_edge(det, lamps, cclr, fclr);
        e.sa   = m_req[0];
        e.sb   = m_req[1];
        e.ca   = CNT_W'(m_cnt[0]);
        e.cb   = CNT_W'(m_cnt[1]);
        e.flt  = m_fault;
        e.code = 2'(m_code);
        sbq.push_back(e);
        mon_en = 1;
    endtask

    task automatic run(input int n, input logic [1:0] det, input logic [5:0] lamps,
                       input bit cclr = 0, input bit fclr = 0, input bit rst = 0);
        for (int i = 0; i < n; i++) cyc(rst, det, lamps, cclr, fclr);
    endtask

    // Monitor: every cycle the DUT presents a fresh output vector.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                n_checks++;
                got.sa = Sa; got.sb = Sb; got.ca = cnt_a; got.cb = cnt_b;
                got.flt = fault; got.code = fault_code;
                if (sbq.size() == 0) begin
                    $display("FAIL scoreboard_underflow t=%0t got=%h", $time, got);
                end else begin
                    e = sbq.pop_front();
                    if (got === e) n_pass++;
                    else $display("FAIL outputs t=%0t got Sa=%b Sb=%b cnt_a=%0d cnt_b=%0d fault=%b code=%0d exp Sa=%b Sb=%b cnt_a=%0d cnt_b=%0d fault=%b code=%0d",
                                  $time, got.sa, got.sb, got.ca, got.cb, got.flt, got.code,
                                  e.sa, e.sb, e.ca, e.cb, e.flt, e.code);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         rem[2];
        logic [1:0] lvl;
        logic [5:0] legal[5];
        logic [5:0] lamps;
        bit         cclr, fclr, rst;
        legal = '{L_RR, L_AG, L_AY, L_BG, L_BY};
        reset_n = 1'b0; det_a = 1'b1; det_b = 1'b1;
        {Ra, Ya, Ga, Rb, Yb, Gb} = L_AG;
        cnt_clr = 1'b0; fault_clr = 1'b0;

        // reset with detectors high and A green
        run(4, 2'b11, L_AG, 0, 0, 1);
        run(6, 2'b00, L_RR);
        // short glitch then real arrival
        run(3, 2'b01, L_RR);
        run(8, 2'b00, L_RR);
        run(10, 2'b01, L_RR);
        // served by green, vehicle gone
        run(10, 2'b00, L_AG);
        // no green: request holds
        run(10, 2'b01, L_RR);
        run(15, 2'b00, L_RR);
        // B arrivals to saturation
        for (int k = 0; k < 9; k++) begin
            run(6, 2'b10, L_RR);
            run(6, 2'b00, L_RR);
        end
        // clear collides with a stable_b rise
        run(5, 2'b10, L_RR);
        run(1, 2'b10, L_RR, 1, 0);
        run(6, 2'b10, L_RR);
        run(6, 2'b00, L_RR);
        // conflict first, later A violation ignored, then clear
        run(1, 2'b00, 6'b001_010);
        run(2, 2'b00, 6'b101_100);
        run(1, 2'b00, L_RR, 0, 1);
        run(2, 2'b00, L_RR);
        // simultaneous A and B violations, clear blocked by new violation
        run(1, 2'b00, 6'b101_101);
        run(1, 2'b00, 6'b011_100, 0, 1);
        run(1, 2'b00, L_RR);
        run(1, 2'b00, L_RR, 0, 1);
        // reset mid-debounce with a pending request
        run(5, 2'b11, L_RR);
        run(2, 2'b11, L_RR, 0, 0, 1);
        run(4, 2'b00, L_RR);

        rem = '{0, 0};
        lvl = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (rem[s] == 0) begin
                    lvl[s] = 1'($urandom_range(0, 1));
                    rem[s] = $urandom_range(1, 10);
                end
                rem[s]--;
            end
            if ($urandom_range(0, 99) < 85) lamps = legal[$urandom_range(0, 4)];
            else                            lamps = 6'($urandom_range(0, 63));
            cclr = $urandom_range(0, 99) < 2;
            fclr = $urandom_range(0, 99) < 6;
            rst  = $urandom_range(0, 999) < 3;
            cyc(rst, lvl, lamps, cclr, fclr);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
